uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

UART receive and word-assembly stage that sits between the board's serial input and the CPU data memory. It deserialises 8N1 frames from `Rx_Serial` and packs four consecutive bytes into a 32-bit word. Each completed word is written into data memory at sequential word addresses. After a fixed word count it raises `load_done`, which the CPU top uses to release the program and later hand memory over for UART readback.

## Interface
- `CLKS_PER_BIT`, default 5, sysclk cycles per serial bit; minimum 4.
- `WORD_COUNT`, default 25, number of words loaded before `load_done`.
- `BASE_ADDR`, default 32'h0000_0000, byte address of the first word; word-aligned.
- `sysclk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `Rx_Serial`  in  1  asynchronous serial line, idle high, 8N1, LSB first.
- `mem_wr`  out  1  one-cycle data-memory write strobe.
- `mem_addr`  out  32  byte address for the write; valid when `mem_wr`=1.
- `mem_wdata`  out  32  assembled word; valid when `mem_wr`=1.
- `busy`  out  1  high while the receiver FSM is outside IDLE.
- `frame_err`  out  1  sticky; set on a stop bit sampled low.
- `load_done`  out  1  sticky; set when the `WORD_COUNT`-th word is written.

## Operation
- Input sync: `Rx_Serial` passes through two flops (reset value 1). All FSM decisions use the second flop `rx_s`.
- FSM states are IDLE, START, DATA and STOP. A bit counter `cnt` runs 0..`CLKS_PER_BIT`-1 and a bit index `bit_idx` runs 0..7.
  - IDLE: when `rx_s`=0, go to START with `cnt`=0.
  - START: when `cnt` = `CLKS_PER_BIT`/2 (integer division), re-sample `rx_s`. If it is 0, go to DATA with `cnt`=0 and `bit_idx`=0. If it is 1, treat it as a glitch and return to IDLE with no other effect.
  - DATA: when `cnt` = `CLKS_PER_BIT`-1, shift `rx_s` into `shreg[bit_idx]` (LSB first) and reset `cnt`. After bit 7, go to STOP.
  - STOP: when `cnt` = `CLKS_PER_BIT`-1, sample `rx_s`. If it is 1, the byte is accepted. If it is 0, set `frame_err`, discard the byte and leave the byte count unchanged. Return to IDLE in both cases.
- Word assembly is big-endian. The first byte of each word goes to [31:24] and the fourth byte to [7:0]. A byte counter `bcnt` runs 0..3.
- On an accepted byte with `bcnt`=3:
  - pulse `mem_wr`;
  - drive `mem_addr` = `BASE_ADDR` + 4·`widx`;
  - increment `widx`;
  - wrap `bcnt` to 0.
- When `widx` reaches `WORD_COUNT`, set `load_done`. Once `load_done`=1, further frames are still received (and can still set `frame_err`), but no byte is assembled and `mem_wr` stays 0.
- `widx` width is clog2(`WORD_COUNT`+1). There is no address wrap; loading stops at `WORD_COUNT`.
- Reset values: `mem_wr`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `busy`=0, `frame_err`=0, `load_done`=0. Internally: FSM in IDLE, `bcnt`=0, `widx`=0, sync flops at 1.

## Timing
- Input latency: 2 cycles from a pin edge to `rx_s`.
- Start validation: `CLKS_PER_BIT`/2 cycles after the falling edge is seen on `rx_s`.
- Data bit sampling: each data bit is sampled `CLKS_PER_BIT` cycles after the previous sample, i.e. near mid-bit.
- Write latency: `mem_wr`, `mem_addr` and `mem_wdata` are registered. They assert in the cycle immediately after the stop-bit sample edge, for exactly one cycle.
- `load_done` rises on the same edge as the final `mem_wr` pulse.
- Back-to-back frames are supported: the FSM is back in IDLE mid-stop-bit and can detect the next start edge.
- Reset mid-frame: a partial byte or partial word is discarded. After reset releases, the line must be idle high before a frame is accepted; a line already low is treated as a start edge.

## Test plan
- Send 0x12, 0x34, 0x56, 0x78 at 5 clk/bit. Required: exactly one `mem_wr`, with `mem_addr`=0x0, `mem_wdata`=0x12345678, and `load_done`=0.
- Send 100 bytes 0x00..0x63. Required: 25 writes; the k-th write has addr 4k and data {4k, 4k+1, 4k+2, 4k+3}; the last is addr 0x60, data 0x60616263; `load_done`=1 on that edge.
- Drive `Rx_Serial` low for 1 cycle, then high. Required: START aborts, no byte, `busy` returns to 0, `frame_err`=0.
- Send 0xAA with the stop bit held 0, then 0x11, 0x22, 0x33, 0x44. Required: `frame_err`=1; a single write with data 0x11223344 at addr 0x0.
- Assert `reset` after two bytes of a word plus half a frame, then send 0xDE, 0xAD, 0xBE, 0xEF. Required: write addr 0x0, data 0xDEADBEEF; `frame_err`=0.
- After `load_done`, send 4 more bytes. Required: no `mem_wr`; `load_done` stays 1.

Source files
------------

// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver that packs four bytes (big-endian) into 32-bit words
// and writes them to data memory at sequential word addresses until
// WORD_COUNT words have been loaded.
module uart_mem_loader #(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned WORD_COUNT   = 25,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        Rx_Serial,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        frame_err,
    output logic        load_done
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned WIDX_W = $clog2(WORD_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchroniser
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q,    rx_s_d;

    // Receiver
    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q,   shreg_d;
    logic              byte_ok;

    // Word assembly
    logic [23:0]       word_q,    word_d;
    logic [1:0]        bcnt_q,    bcnt_d;
    logic [WIDX_W-1:0] widx_q,    widx_d;

    // Registered outputs
    logic              mem_wr_q,    mem_wr_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q,      busy_d;
    logic              frame_err_q, frame_err_d;
    logic              load_done_q, load_done_d;

    // All state registers with synchronous active-high reset
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            word_q      <= '0;
            bcnt_q      <= '0;
            widx_q      <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            widx_q      <= widx_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            load_done_q <= load_done_d;
        end
    end

    // Two-flop synchroniser on the serial input
    always_comb begin
        rx_meta_d = Rx_Serial;
        rx_s_d    = rx_meta_q;
    end

    // Receiver FSM: start validation at half-bit, data/stop sampled every bit period
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = frame_err_q;
        byte_ok     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shreg_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rx_s_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Big-endian word assembly and memory write generation
    always_comb begin
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        widx_d      = widx_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = load_done_q;

        if (byte_ok && !load_done_q) begin
            word_d = {word_q[15:0], shreg_q};
            if (bcnt_q == 2'd3) begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = BASE_ADDR + (32'(widx_q) << 2);
                mem_wdata_d = {word_q, shreg_q};
                widx_d      = widx_q + WIDX_W'(1);
                bcnt_d      = 2'd0;
                if (widx_q == WIDX_LAST) begin
                    load_done_d = 1'b1;
                end
            end else begin
                bcnt_d = bcnt_q + 2'd1;
            end
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed and random serial
// frames compared against a byte-stream reference model.
module tb_uart_mem_loader;

    localparam int unsigned CPB  = 5;
    localparam int unsigned WC   = 25;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        frame_err;
    logic        load_done;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .WORD_COUNT  (WC),
        .BASE_ADDR   (BASE)
    ) dut (
        .sysclk   (clk),
        .reset    (reset),
        .Rx_Serial(rx),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .frame_err(frame_err),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_writes = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    wr_t         exp_q[$];

    // Reference model: a stream of accepted bytes grouped into words
    logic [31:0] m_word;
    int          m_bytes;
    int          m_widx;
    logic        m_done;
    logic        m_ferr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_word  = '0;
        m_bytes = 0;
        m_widx  = 0;
        m_done  = 1'b0;
        m_ferr  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        wr_t e;
        if (!good) begin
            m_ferr = 1'b1;
        end else if (!m_done) begin
            m_word  = (m_word << 8) | 32'(b);
            m_bytes = m_bytes + 1;
            if (m_bytes == 4) begin
                e.addr  = BASE + 32'(4 * m_widx);
                e.data  = m_word;
                e.done  = (m_widx + 1 == WC);
                exp_q.push_back(e);
                m_widx  = m_widx + 1;
                m_bytes = 0;
                m_word  = '0;
                if (m_widx == WC) m_done = 1'b1;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        model_byte(b, stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        if (!stop_bit) begin
            rx = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_clear();
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_addr",  mem_addr,       BASE);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
    endtask

    task automatic finish_phase(input string tag, input int w0, input int nw);
        tick(3 * CPB);
        check({tag, "_pending"},   32'(exp_q.size()),    32'd0);
        check({tag, "_nwrites"},   32'(n_writes - w0),   32'(nw));
        check({tag, "_frame_err"}, 32'(frame_err),       32'(m_ferr));
        check({tag, "_load_done"}, 32'(load_done),       32'(m_done));
        check({tag, "_busy"},      32'(busy),            32'd0);
    endtask

    // Write monitor: every mem_wr must match the next expected write
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr",      mem_addr,        e.addr);
                check("wr_data",      mem_wdata,       e.data);
                check("wr_load_done", 32'(load_done),  32'(e.done));
            end
        end
    end

    initial begin
        int w0;
        logic [7:0] b;
        logic good;

        model_clear();

        // Single word
        do_reset();
        w0 = n_writes;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        send_frame(8'h56, 1'b1);
        send_frame(8'h78, 1'b1);
        finish_phase("one_word", w0, 1);

        // One-cycle glitch on the line
        do_reset();
        w0 = n_writes;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        finish_phase("glitch", w0, 0);

        // Framing error then a clean word
        do_reset();
        w0 = n_writes;
        send_frame(8'hAA, 1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        finish_phase("ferr", w0, 1);

        // Reset in the middle of a partial word and partial frame
        do_reset();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b1;
        tick(2);
        do_reset();
        w0 = n_writes;
        send_frame(8'hDE, 1'b1);
        send_frame(8'hAD, 1'b1);
        send_frame(8'hBE, 1'b1);
        send_frame(8'hEF, 1'b1);
        finish_phase("mid_reset", w0, 1);

        // Random bytes, random framing errors, random inter-frame gaps
        do_reset();
        w0 = n_writes;
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_frame(b, good);
            tick($urandom_range(0, 3));
        end
        finish_phase("random", w0, m_widx);

        // Full load of 100 counting bytes
        do_reset();
        w0 = n_writes;
        for (int i = 0; i < 100; i++) send_frame(8'(i), 1'b1);
        finish_phase("full_load", w0, WC);

        // Frames after load_done are ignored for assembly
        w0 = n_writes;
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
        finish_phase("post_load", w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
